sobel_edge_stream: RTL and testbench

- Parametrised, pipelined Sobel edge detector for the grayscale filter path.
- Consumes one 3x3 window per accepted beat from the line-buffer/window generator. Emits one replicated-gray RGB pixel to the display/frame-buffer writer.
- Adds over the earlier fixed 4-bit filter:
  - generic pixel width;
  - true |gx|+|gy| magnitude;
  - selectable output mode and binary threshold;
  - valid/ready backpressure;
  - frame-synchronous mode/threshold update.

---
 rtl/edge_pkg.sv | 17 +
 rtl/sobel_grad_core.sv | 49 ++++
 rtl/sobel_edge_stream.sv | 145 ++++++++++++++
 tb/tb_sobel_edge_stream.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared constants and helpers for the Sobel edge filter path.
// Holds the output-mode encoding and the gradient width derivation.
// No logic; pure declarations.
package edge_pkg;

  localparam logic [1:0] MODE_MAG = 2'd0;
  localparam logic [1:0] MODE_GX  = 2'd1;
  localparam logic [1:0] MODE_GY  = 2'd2;
  localparam logic [1:0] MODE_BIN = 2'd3;

  // Gradient width: a 1-2-1 weighted column sum of PIX_W-bit pixels needs
  // PIX_W+2 bits unsigned, plus one sign bit once the two sums are subtracted.
  function automatic int gw_of(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_grad_core.sv
// Sobel gradient arithmetic: S1 weighted partial sums and S2 subtract/abs.
// Latency: purely combinational; the caller registers between the two halves.
// Backpressure: none here; the caller's stage enables freeze the operands.
// Ports: pixel_in (3x3 window, p00 in MSBs) -> xp/xn/yp/yn;
//        s_xp/s_xn/s_yp/s_yn (registered sums) -> ax/ay magnitudes.
module sobel_grad_core
  import edge_pkg::*;
#(
  parameter int PIX_W = 4,
  localparam int GW = gw_of(PIX_W),
  localparam int SW = GW - 1
) (
  input  logic [9*PIX_W-1:0] pixel_in,
  output logic [SW-1:0]      xp,
  output logic [SW-1:0]      xn,
  output logic [SW-1:0]      yp,
  output logic [SW-1:0]      yn,
  input  logic [SW-1:0]      s_xp,
  input  logic [SW-1:0]      s_xn,
  input  logic [SW-1:0]      s_yp,
  input  logic [SW-1:0]      s_yn,
  output logic [SW-1:0]      ax,
  output logic [SW-1:0]      ay
);

  // p[0]=p00 ... p[8]=p22, row-major.
  logic [SW-1:0] p [9];

  for (genvar i = 0; i < 9; i++) begin : g_unpack
    assign p[i] = SW'(pixel_in[(8-i)*PIX_W +: PIX_W]);
  end

  assign xp = p[2] + (p[5] << 1) + p[8];
  assign xn = p[0] + (p[3] << 1) + p[6];
  assign yp = p[0] + (p[1] << 1) + p[2];
  assign yn = p[6] + (p[7] << 1) + p[8];

  logic signed [GW-1:0] gx, gy, ngx, ngy;

  assign gx  = $signed({1'b0, s_xp}) - $signed({1'b0, s_xn});
  assign gy  = $signed({1'b0, s_yp}) - $signed({1'b0, s_yn});
  assign ngx = -gx;
  assign ngy = -gy;

  // |g| never exceeds 4*(2^PIX_W-1), so it fits back into SW bits.
  assign ax = gx[GW-1] ? ngx[SW-1:0] : gx[SW-1:0];
  assign ay = gy[GW-1] ? ngy[SW-1:0] : gy[SW-1:0];

endmodule

// File: rtl/sobel_edge_stream.sv
// Pipelined Sobel edge detector: 3x3 gray window in, replicated-gray RGB out.
// Latency: 3 clk from accepted window to out_valid; one pixel per clk sustained.
// Backpressure: whole pipe freezes when out_valid && !out_ready; in_ready mirrors it.
// Ports: in_valid/in_ready/in_sof/pixel_in window stream, mode_cfg/thresh_cfg
//        (taken on accepted sof beats), out_valid/out_ready/out_sof/pixel_out.
module sobel_edge_stream
  import edge_pkg::*;
#(
  parameter int PIX_W = 4,
  parameter int SHIFT = 1,
  localparam int GW = gw_of(PIX_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic [9*PIX_W-1:0]   pixel_in,
  input  logic [1:0]           mode_cfg,
  input  logic [GW-1:0]        thresh_cfg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic [3*PIX_W-1:0]   pixel_out
);

  localparam int SW = GW - 1;
  localparam logic [PIX_W-1:0] PMAX = '1;

  logic advance, accept;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Frame-level configuration; only a sof beat may replace it.
  logic [1:0]    cfg_mode;
  logic [GW-1:0] cfg_thr;
  logic [1:0]    eff_mode;
  logic [GW-1:0] eff_thr;

  assign eff_mode = in_sof ? mode_cfg   : cfg_mode;
  assign eff_thr  = in_sof ? thresh_cfg : cfg_thr;

  logic          s1_vld, s1_sof;
  logic [1:0]    s1_mode;
  logic [GW-1:0] s1_thr;
  logic [SW-1:0] s1_xp, s1_xn, s1_yp, s1_yn;

  logic          s2_vld, s2_sof;
  logic [1:0]    s2_mode;
  logic [GW-1:0] s2_thr;
  logic [SW-1:0] s2_ax, s2_ay;

  logic [SW-1:0] c_xp, c_xn, c_yp, c_yn, c_ax, c_ay;

  sobel_grad_core #(.PIX_W(PIX_W)) u_grad (
    .pixel_in (pixel_in),
    .xp       (c_xp),
    .xn       (c_xn),
    .yp       (c_yp),
    .yn       (c_yn),
    .s_xp     (s1_xp),
    .s_xn     (s1_xn),
    .s_yp     (s1_yp),
    .s_yn     (s1_yn),
    .ax       (c_ax),
    .ay       (c_ay)
  );

  // S3 select / saturate.
  logic [GW-1:0]    sum, mag_sh, gx_sh, gy_sh;
  logic [PIX_W-1:0] g;

  function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] v);
    return (v > GW'(PMAX)) ? PMAX : v[PIX_W-1:0];
  endfunction

  always_comb begin
    sum    = GW'(s2_ax) + GW'(s2_ay);
    mag_sh = sum >> SHIFT;
    gx_sh  = GW'(s2_ax) >> SHIFT;
    gy_sh  = GW'(s2_ay) >> SHIFT;
    g      = '0;
    case (s2_mode)
      MODE_MAG: g = sat(mag_sh);
      MODE_GX:  g = sat(gx_sh);
      MODE_GY:  g = sat(gy_sh);
      MODE_BIN: g = (sum >= s2_thr) ? PMAX : '0;
      default:  g = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_mode  <= MODE_MAG;
      cfg_thr   <= '0;
      s1_vld    <= 1'b0;
      s1_sof    <= 1'b0;
      s1_mode   <= MODE_MAG;
      s1_thr    <= '0;
      s1_xp     <= '0;
      s1_xn     <= '0;
      s1_yp     <= '0;
      s1_yn     <= '0;
      s2_vld    <= 1'b0;
      s2_sof    <= 1'b0;
      s2_mode   <= MODE_MAG;
      s2_thr    <= '0;
      s2_ax     <= '0;
      s2_ay     <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      pixel_out <= '0;
    end else begin
      if (accept && in_sof) begin
        cfg_mode <= mode_cfg;
        cfg_thr  <= thresh_cfg;
      end
      if (advance) begin
        s1_vld  <= accept;
        s1_sof  <= accept && in_sof;
        s1_mode <= eff_mode;
        s1_thr  <= eff_thr;
        s1_xp   <= c_xp;
        s1_xn   <= c_xn;
        s1_yp   <= c_yp;
        s1_yn   <= c_yn;

        s2_vld  <= s1_vld;
        s2_sof  <= s1_sof;
        s2_mode <= s1_mode;
        s2_thr  <= s1_thr;
        s2_ax   <= c_ax;
        s2_ay   <= c_ay;

        out_valid <= s2_vld;
        out_sof   <= s2_sof;
        if (s2_vld) begin
          pixel_out <= {3{g}};
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_stream.sv
module tb_sobel_edge_stream;

  localparam int PIX_W = 4;
  localparam int SHIFT = 1;
  localparam int GW    = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sof = 1'b0;
  logic [35:0]       pixel_in = '0;
  logic [1:0]        mode_cfg = '0;
  logic [GW-1:0]     thresh_cfg = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_sof;
  logic [11:0]       pixel_out;

  sobel_edge_stream #(.PIX_W(PIX_W), .SHIFT(SHIFT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .pixel_in   (pixel_in),
    .mode_cfg   (mode_cfg),
    .thresh_cfg (thresh_cfg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .pixel_out  (pixel_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pix;
    logic        sof;
    int          acc;
    logic        chk;
    logic        seen;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic        accepted;
  logic        full_rate;
  logic [11:0] last_pix;
  logic [1:0]  m_mode = 2'd0;
  int          m_thr = 0;

  // Reference: plain integer Sobel arithmetic straight from the filter rules.
  function automatic logic [11:0] model(input logic [35:0] w, input logic [1:0] m, input int thr);
    int p[9];
    int gx, gy, ax, ay, s, g;
    logic [3:0] g4;
    for (int i = 0; i < 9; i++) p[i] = int'(w[(8-i)*4 +: 4]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[0] + 2*p[1] + p[2]) - (p[6] + 2*p[7] + p[8]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    s  = ax + ay;
    case (m)
      2'd0: g = s >> SHIFT;
      2'd1: g = ax >> SHIFT;
      2'd2: g = ay >> SHIFT;
      default: g = (s >= thr) ? 15 : 0;
    endcase
    if (g > 15) g = 15;
    g4 = g[3:0];
    return {g4, g4, g4};
  endfunction

  function automatic logic [35:0] rows(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {a, b, c, a, b, c, a, b, c};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_out();
    if (out_valid) begin
      if (q.size() == 0) begin
        cmp("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        cmp("pixel_out", 32'(pixel_out), 32'(q[0].pix));
        cmp("out_sof", 32'(out_sof), 32'(q[0].sof));
        if (q[0].chk && !q[0].seen) cmp("latency", 32'(cyc), 32'(q[0].acc + 3));
        q[0].seen = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic iv, input logic sof, input logic [35:0] w,
                      input logic [1:0] m, input logic [GW-1:0] thr, input logic ordy);
    exp_t e;
    logic [1:0] um;
    int ut;
    @(negedge clk);
    cyc++;
    check_out();
    in_valid   = iv;
    in_sof     = sof;
    pixel_in   = w;
    mode_cfg   = m;
    thresh_cfg = thr;
    out_ready  = ordy;
    #1;
    cmp("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    accepted = in_valid && in_ready;
    if (out_valid && out_ready && q.size() > 0) begin
      last_pix = pixel_out;
      void'(q.pop_front());
    end
    if (accepted) begin
      if (sof) begin
        m_mode = m;
        m_thr  = int'(thr);
      end
      um = sof ? m : m_mode;
      ut = sof ? int'(thr) : m_thr;
      e.pix  = model(w, um, ut);
      e.sof  = sof;
      e.acc  = cyc;
      e.chk  = full_rate;
      e.seen = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    while (q.size() > 0 && budget > 0) begin
      tick(1'b0, 1'b0, '0, 2'd0, '0, 1'b1);
      budget--;
    end
    if (q.size() > 0) begin
      cmp("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic one(input string name, input logic [35:0] w, input logic sof,
                     input logic [1:0] m, input logic [GW-1:0] thr, input logic [11:0] lit);
    int budget;
    budget = 20;
    accepted = 1'b0;
    while (!accepted && budget > 0) begin
      tick(1'b1, sof, w, m, thr, 1'b1);
      budget--;
    end
    if (!accepted) cmp("accept_timeout", 32'd0, 32'd1);
    drain();
    cmp(name, 32'(last_pix), 32'(lit));
  endtask

  initial begin
    int sent;
    logic [35:0] w;
    full_rate = 1'b1;
    last_pix  = '0;

    // Reset state.
    #12;
    cmp("rst_out_valid", 32'(out_valid), 32'd0);
    cmp("rst_out_sof", 32'(out_sof), 32'd0);
    cmp("rst_pixel_out", 32'(pixel_out), 32'd0);
    cmp("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed windows with hand-computed results.
    one("flat_mag", rows(4'd7, 4'd7, 4'd7), 1'b1, 2'd0, 7'd0, 12'h000);
    one("col02_mag", rows(4'd0, 4'd9, 4'd2), 1'b1, 2'd0, 7'd0, 12'h444);
    one("col15_0_gx", rows(4'd15, 4'd3, 4'd0), 1'b1, 2'd1, 7'd0, 12'hFFF);
    one("col15_0_gy", rows(4'd15, 4'd3, 4'd0), 1'b1, 2'd2, 7'd0, 12'h000);
    one("bin_thr8", rows(4'd0, 4'd5, 4'd2), 1'b1, 2'd3, 7'd8, 12'hFFF);
    one("bin_thr9", rows(4'd0, 4'd5, 4'd2), 1'b1, 2'd3, 7'd9, 12'h000);
    one("bin_nonsof_ignored", rows(4'd0, 4'd5, 4'd2), 1'b0, 2'd0, 7'd8, 12'h000);
    // sof without valid must not touch the stored config.
    tick(1'b0, 1'b1, '0, 2'd0, 7'd0, 1'b1);
    one("sof_no_valid_ignored", rows(4'd0, 4'd5, 4'd2), 1'b0, 2'd0, 7'd0, 12'h000);

    // Six windows with a 4-cycle downstream stall in the middle.
    full_rate = 1'b0;
    sent = 0;
    for (int i = 0; i < 30 && (sent < 6 || q.size() > 0); i++) begin
      w[31:0]  = $urandom();
      w[35:32] = 4'($urandom_range(0, 15));
      tick(sent < 6, sent == 0, w, 2'd0, 7'd0, !(i >= 4 && i < 8));
      if (accepted) sent++;
    end
    cmp("stall_sent", 32'(sent), 32'd6);
    drain();

    // Reset with three beats in flight.
    full_rate = 1'b1;
    tick(1'b1, 1'b1, rows(4'd0, 4'd5, 4'd2), 2'd3, 7'd100, 1'b1);
    tick(1'b1, 1'b0, rows(4'd1, 4'd5, 4'd2), 2'd0, 7'd0, 1'b1);
    tick(1'b1, 1'b0, rows(4'd2, 4'd5, 4'd2), 2'd0, 7'd0, 1'b1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    cmp("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    cmp("async_rst_out_valid", 32'(out_valid), 32'd0);
    q.delete();
    m_mode = 2'd0;
    m_thr  = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("post_rst_out_valid", 32'(out_valid), 32'd0);
    cmp("post_rst_in_ready", 32'(in_ready), 32'd1);
    one("post_rst_mode_mag", rows(4'd0, 4'd5, 4'd2), 1'b0, 2'd3, 7'd0, 12'h444);

    // Randomised traffic with random backpressure and frame starts.
    full_rate = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      w[31:0]  = $urandom();
      w[35:32] = 4'($urandom_range(0, 15));
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0, w,
           2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
           $urandom_range(0, 3) != 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
